// File: rtl/divider.sv
// 32-bit signed/unsigned restoring divider, one quotient bit per cycle: result = {remainder, quotient}.
// Define DIV_BYZERO_FAST_EN to short-cut a zero divisor through the BYZERO state (result 0, ready in cycle 2).
`timescale 1ns/1ps
module divider (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div,
    input  logic [31:0] opdata1,
    input  logic [31:0] opdata2,
    input  logic        start,
    input  logic        annul,
    output logic [63:0] result,
    output logic        ready,
    output logic        div_stall
);

`ifdef DIV_BYZERO_FAST_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_BYZERO = 2'd1, S_ON = 2'd2, S_END = 2'd3} state_e;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_ON = 2'd2, S_END = 2'd3} state_e;
`endif

    state_e      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [63:0] rem_q, rem_d;       // {partial remainder, dividend bits becoming quotient}
    logic [31:0] dvsr_q, dvsr_d;
    logic        signed_q, signed_d;
    logic        q_neg_q, q_neg_d;
    logic        r_neg_q, r_neg_d;
    logic [63:0] result_q, result_d;

    logic [63:0] shifted;
    logic [32:0] diff;
    logic [63:0] step_rem;
    logic [31:0] q_fix, r_fix;
    logic [31:0] a_mag, b_mag;
    logic        accept;

    assign accept = start & ~annul;
    assign a_mag  = (signed_div & opdata1[31]) ? (~opdata1 + 32'd1) : opdata1;
    assign b_mag  = (signed_div & opdata2[31]) ? (~opdata2 + 32'd1) : opdata2;

    // A negative 33-bit difference means the divisor did not fit: keep the shifted value, quotient bit 0.
    assign shifted  = rem_q << 1;
    assign diff     = {1'b0, shifted[63:32]} - {1'b0, dvsr_q};
    assign step_rem = diff[32] ? shifted : {diff[31:0], shifted[31:1], 1'b1};
    assign q_fix    = (signed_q & q_neg_q) ? (~step_rem[31:0] + 32'd1) : step_rem[31:0];
    assign r_fix    = (signed_q & r_neg_q) ? (~step_rem[63:32] + 32'd1) : step_rem[63:32];

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d  = state_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        dvsr_d   = dvsr_q;
        signed_d = signed_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    rem_d    = {32'd0, a_mag};
                    dvsr_d   = b_mag;
                    cnt_d    = 5'd0;
                    signed_d = signed_div;
                    q_neg_d  = signed_div & (opdata1[31] ^ opdata2[31]);
                    r_neg_d  = signed_div & opdata1[31];
`ifdef DIV_BYZERO_FAST_EN
                    state_d  = (opdata2 == 32'd0) ? S_BYZERO : S_ON;
`else
                    state_d  = S_ON;
`endif
                end
            end
`ifdef DIV_BYZERO_FAST_EN
            S_BYZERO: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    state_d  = S_END;
                    result_d = 64'd0;
                end
            end
`endif
            S_ON: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = step_rem;
                    cnt_d = cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        state_d  = S_END;
                        result_d = {r_fix, q_fix};
                    end
                end
            end
            S_END:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            rem_q    <= 64'd0;
            dvsr_q   <= 32'd0;
            signed_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rem_q    <= rem_d;
            dvsr_q   <= dvsr_d;
            signed_q <= signed_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            result_q <= result_d;
        end
    end

    // While reset is held the block behaves as if already in IDLE.
    always_comb begin
        result = result_q;
        ready  = 1'b0;
        if (rst) begin
            div_stall = accept;
        end else begin
            ready     = (state_q == S_END);
            div_stall = ((state_q == S_IDLE) & accept)
`ifdef DIV_BYZERO_FAST_EN
                      | (state_q == S_BYZERO)
`endif
                      | (state_q == S_ON);
        end
    end

endmodule

// File: tb/tb_divider.sv
// Directed self-checking bench for divider: latency, signed fix-up, annul, reset and back-to-back cases.
// Expectations for a zero divisor follow DIV_BYZERO_FAST_EN when it is defined for the bench too.
`timescale 1ns/1ps
module tb_divider;

    logic        clk = 1'b0;
    logic        rst, signed_div, start, annul;
    logic [31:0] opdata1, opdata2;
    logic [63:0] result;
    logic        ready, div_stall;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    divider dut (
        .clk        (clk),
        .rst        (rst),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .start      (start),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .div_stall  (div_stall)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Cycle boundary: inputs change 1ns after the rising edge, outputs are sampled 3ns later.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Issues one division from cycle 0; start drops once ready is seen or when annul fires.
    task automatic run_div(input logic sd, input logic [31:0] a, input logic [31:0] b,
                           input int annul_at, input int budget,
                           output int rdy_at, output int rdy_n, output int stall_n);
        logic seen;
        signed_div = sd; opdata1 = a; opdata2 = b; start = 1'b1; annul = 1'b0;
        rdy_at = -1; rdy_n = 0; stall_n = 0;
        for (int c = 0; c < budget; c++) begin
            annul = (c == annul_at);
            if (c == annul_at) start = 1'b0;
            #3;
            seen = ready;
            if (div_stall) stall_n++;
            if (ready) begin
                rdy_n++;
                if (rdy_at < 0) rdy_at = c;
            end
            next_cycle();
            if (seen) start = 1'b0;
        end
        start = 1'b0; annul = 1'b0;
    endtask

    int          rdy_at, rdy_n, stall_n, r1, r2;
    logic [63:0] res1, res2;

    initial begin
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0;
        opdata1 = '0; opdata2 = '0;
        next_cycle();
        next_cycle();

        // Reset-held outputs
        start = 1'b1; opdata1 = 32'd100; opdata2 = 32'd7; #3;
        check("rst_ready", ready, 0);
        check("rst_stall_start", div_stall, 1);
        check("rst_result", result, 0);
        annul = 1'b1; #1;
        check("rst_stall_annul", div_stall, 0);
        next_cycle();
        rst = 1'b0; start = 1'b0; annul = 1'b0; #3;
        check("idle_stall", div_stall, 0);
        next_cycle();

        // annul in IDLE blocks acceptance
        start = 1'b1; annul = 1'b1; #3;
        check("idle_annul_stall", div_stall, 0);
        next_cycle();
        start = 1'b0; annul = 1'b0; #3;
        check("idle_annul_not_accepted", div_stall, 0);
        next_cycle();

        run_div(1'b0, 32'd100, 32'd7, -1, 40, rdy_at, rdy_n, stall_n);
        check("u100_7_ready_cycle", rdy_at, 33);
        check("u100_7_ready_count", rdy_n, 1);
        check("u100_7_stall_cycles", stall_n, 33);
        check("u100_7_result", result, 64'h00000002_0000000E);

        run_div(1'b1, 32'hFFFFFFF9, 32'h2, -1, 40, rdy_at, rdy_n, stall_n);
        check("s_m7_2_ready_cycle", rdy_at, 33);
        check("s_m7_2_result", result, 64'hFFFFFFFF_FFFFFFFD);

        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, -1, 40, rdy_at, rdy_n, stall_n);
        check("s_min_m1_result", result, 64'h00000000_80000000);

        run_div(1'b1, 32'd7, 32'hFFFFFFFE, -1, 40, rdy_at, rdy_n, stall_n);
        check("s_7_m2_result", result, 64'h00000001_FFFFFFFD);

        // annul in cycle 10 of a division
        run_div(1'b0, 32'd100, 32'd7, 10, 40, rdy_at, rdy_n, stall_n);
        check("annul_ready_count", rdy_n, 0);
        check("annul_stall_cycles", stall_n, 11);
        check("annul_result_kept", result, 64'h00000001_FFFFFFFD);

        run_div(1'b0, 32'd9, 32'd3, -1, 40, rdy_at, rdy_n, stall_n);
        check("u9_3_ready_cycle", rdy_at, 33);
        check("u9_3_result", result, 64'h00000000_00000003);

        run_div(1'b0, 32'hFFFFFFFF, 32'h10, -1, 40, rdy_at, rdy_n, stall_n);
        check("uffff_16_result", result, 64'h0000000F_0FFFFFFF);

        run_div(1'b0, 32'd7, 32'd0, -1, 40, rdy_at, rdy_n, stall_n);
`ifdef DIV_BYZERO_FAST_EN
        check("u7_0_ready_cycle", rdy_at, 2);
        check("u7_0_stall_cycles", stall_n, 2);
        check("u7_0_result", result, 64'h0);
`else
        check("u7_0_ready_cycle", rdy_at, 33);
        check("u7_0_stall_cycles", stall_n, 33);
        check("u7_0_result", result, 64'h00000007_FFFFFFFF);
`endif

        // annul while in END: ready still pulses, result committed
        run_div(1'b0, 32'd1000, 32'd10, 33, 40, rdy_at, rdy_n, stall_n);
        check("end_annul_ready_cycle", rdy_at, 33);
        check("end_annul_ready_count", rdy_n, 1);
        check("end_annul_result", result, 64'h00000000_00000064);

        // Reset in cycle 5 of a division
        signed_div = 1'b0; opdata1 = 32'd100; opdata2 = 32'd7; start = 1'b1;
        for (int c = 0; c < 5; c++) next_cycle();
        rst = 1'b1; start = 1'b0; #3;
        check("rst_mid_ready", ready, 0);
        check("rst_mid_stall", div_stall, 0);
        next_cycle();
        rst = 1'b0; #3;
        check("rst_mid_after_ready", ready, 0);
        check("rst_mid_after_stall", div_stall, 0);
        check("rst_mid_after_result", result, 64'h0);
        rdy_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (ready) rdy_n++;
            next_cycle();
            #3;
        end
        check("rst_mid_no_ready", rdy_n, 0);
        next_cycle();

        // Back-to-back: 20/6 then 9/4 with start held high throughout
        signed_div = 1'b0; opdata1 = 32'd20; opdata2 = 32'd6; start = 1'b1;
        r1 = -1; r2 = -1; res1 = '0; res2 = '0;
        for (int c = 0; c < 80; c++) begin
            #3;
            if (ready) begin
                if (r1 < 0) begin
                    r1 = c; res1 = result;
                end else if (r2 < 0) begin
                    r2 = c; res2 = result;
                end
            end
            next_cycle();
            if (c == r1) begin
                opdata1 = 32'd9; opdata2 = 32'd4;
            end
            if (c == r2) start = 1'b0;
        end
        start = 1'b0;
        check("b2b_first_cycle", r1, 33);
        check("b2b_first_result", res1, 64'h00000002_00000003);
        check("b2b_second_cycle", r2, 67);
        check("b2b_second_result", res2, 64'h00000001_00000002);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 The block SHALL have a single clock `clk` (input, 1) and the synchronous, active-high reset `rst` (input, 1), listed first; all state updates occur on the rising edge of `clk`.
REQ-002 `signed_div`, input, 1: 1 selects two's-complement division, 0 selects unsigned; sampled with `start`.
REQ-003 `opdata1`, input, 32: dividend; sampled in the IDLE cycle in which `start` is accepted.
REQ-004 `opdata2`, input, 32: divisor; sampled with `opdata1`.
REQ-005 `start`, input, 1: E-stage div/divu request; held high by the pipeline while the instruction sits in E.
REQ-006 `annul`, input, 1: cancels any in-flight or requested division (exception or flush).
REQ-007 `result`, output, 64: bits [63:32] are the remainder (HI); bits [31:0] are the quotient (LO).
REQ-008 `ready`, output, 1: result valid; high for exactly one cycle per completed division.
REQ-009 `div_stall`, output, 1: feeds the hazard unit; high while the division is incomplete.

Function
REQ-010 The block SHALL be a four-state FSM: IDLE, BYZERO, ON, END.
REQ-011 In IDLE, `start`=1 with `annul`=0 SHALL latch the operands and `signed_div`. The next state is BYZERO if `opdata2`==0 and DIV_BYZERO_FAST_EN is defined; otherwise it is ON.
REQ-012 On acceptance in signed mode, the block SHALL latch the absolute values of both operands and record the sign of the quotient (dividend sign XOR divisor sign) and the sign of the remainder (dividend sign).
REQ-013 ON SHALL perform one restoring-division step per cycle over a 5-bit counter 0..31; when the counter is 31 the next state is END.
REQ-014 The restoring step SHALL shift the 64-bit partial remainder left by 1, subtract the divisor magnitude from bits [63:32] using 33-bit arithmetic, and keep the difference only if it is non-negative; the quotient bit is 1 if kept, else 0.
REQ-015 On the transition into END, the block SHALL load `result` with the magnitudes, negated per the REQ-012 signs when signed. Arithmetic is mod 2^32: 0x80000000/0xFFFFFFFF gives quotient 0x80000000, remainder 0.
REQ-016 In END, `ready` SHALL be 1 and `div_stall` 0; END always transitions to IDLE on the next cycle.
REQ-017 `div_stall` SHALL be (IDLE & `start` & ~`annul`) | BYZERO | ON, with no registered delay.
REQ-018 Latency without annul: acceptance in cycle 0, ON in cycles 1–32, END/`ready` in cycle 33, `div_stall` high in cycles 0–32 (33 cycles).
REQ-019 `result` SHALL hold its value until the next transition into END; it is not cleared on IDLE.
REQ-020 If `annul`=1 in BYZERO or ON, the next state SHALL be IDLE; `ready` is not asserted and `result` is unchanged.
REQ-021 If `annul`=1 in END, `ready` SHALL remain 1 for that cycle because the result is already committed, and the next state is IDLE.
REQ-022 In IDLE, `annul`=1 SHALL block acceptance and force `div_stall`=0.
REQ-023 `start` high in the cycle after END (a back-to-back div) SHALL be accepted as a new division in IDLE.

Reset
REQ-024 `rst`=1 at a clock edge SHALL force IDLE, counter 0, `result`=0 and all internal operand and sign registers to 0, from any state including mid-division.
REQ-025 While `rst` is high, `ready` SHALL be 0 and `div_stall` SHALL equal REQ-017 evaluated in IDLE.

Configuration
REQ-026 With macro DIV_BYZERO_FAST_EN defined, divisor==0 SHALL go IDLE→BYZERO→END, giving `result`=64'h0 and `ready` in cycle 2 with `div_stall` high in cycles 0–1.
REQ-027 Without DIV_BYZERO_FAST_EN, the BYZERO state SHALL not exist and divisor==0 runs the full 32 steps.
- Magnitude result: quotient 0xFFFFFFFF, remainder = |dividend|, then REQ-015 sign fix-up.
- `ready` arrives in cycle 33.

Verification
REQ-028 Unsigned 100/7: `ready` in cycle 33, `result`=64'h00000002_0000000E, `div_stall` high exactly 33 cycles.
REQ-029 Signed -7/2 (0xFFFFFFF9/0x2): `result`=64'hFFFFFFFF_FFFFFFFD; signed 0x80000000/0xFFFFFFFF: `result`=64'h00000000_80000000.
REQ-030 Start unsigned 100/7, `annul` in cycle 10: IDLE in cycle 11, `ready` never asserted, `result` unchanged; a following 9/3 yields 64'h00000000_00000003.
REQ-031 Unsigned 7/0:
- with DIV_BYZERO_FAST_EN: `result`=0, `ready` in cycle 2.
- without it: `result`=64'h00000007_FFFFFFFF, `ready` in cycle 33.
REQ-032 `rst` asserted in cycle 5 of a division: IDLE next cycle, `result`=0, `ready`=0, `div_stall`=0 with `start` low.
REQ-033 Back-to-back: 20/6 then `start` held for 9/4: ready pulses in cycle 33 (64'h00000002_00000003) and cycle 67 (64'h00000001_00000002).
